// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
//   state_e           : arbiter FSM states (IDLE, ACCESS, RESP)
//   port_e            : requester identity (PORT_I = fetch, PORT_D = load/store)
//   MEM_WORDS_DEFAULT : default depth of the attached memory in 32-bit words
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam int unsigned MEM_WORDS_DEFAULT = 16000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant decision (purely combinational).
// Ports:
//   req_i[1:0] : requests, bit 0 = instruction port, bit 1 = data port
//   last_i     : port that received the previous grant
//   en_i       : grants are only allowed while high
//   gnt_o[1:0] : one-hot grant, same bit order as req_i
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_e      last_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        // Conflict: favour whichever port did not win last time.
        2'b11:   gnt_o = (last_i == PORT_I) ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported word memory between an instruction-fetch port
// and a data load/store port. Each transaction takes three cycles:
// grant (IDLE), memory access (ACCESS), response (RESP).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt         : fetch request and its accept pulse
//   i_rvalid/i_rdata              : fetch response
//   d_req/d_we/d_addr/d_wdata     : data request (d_we = 1 for store)
//   d_gnt, d_rvalid/d_rdata       : data accept pulse and completion
//   err                           : faulting access, coincident with rvalid
//   mem_A/mem_WD/mem_We, mem_RD   : memory side, read data combinational
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_WD,
  output logic                  mem_We,
  input  logic [DATA_WIDTH-1:0] mem_RD
);

  state_e                state_q, state_d;
  port_e                 last_q, last_d;
  port_e                 port_q, port_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [1:0]            req_vec;
  logic [1:0]            gnt_vec;
  logic                  sel_d;
  logic [DATA_WIDTH-1:0] cap_addr;
  logic                  in_access;
  logic                  in_resp;

  // Misaligned or beyond the end of the memory.
  function automatic logic is_fault(input logic [DATA_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] word;
    word = a >> 2;
    return (a[1:0] != 2'b00) || (word >= DATA_WIDTH'(MEM_WORDS));
  endfunction

  assign req_vec = {d_req, i_req};

  // Grants are masked during reset so an aborted cycle never starts a transfer.
  rr_arbiter2 u_rr (
    .req_i  (req_vec),
    .last_i (last_q),
    .en_i   ((state_q == IDLE) && !rst),
    .gnt_o  (gnt_vec)
  );

  assign sel_d    = gnt_vec[1];
  assign cap_addr = sel_d ? d_addr : i_addr;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|gnt_vec) begin
          state_d = ACCESS;
          last_d  = sel_d ? PORT_D : PORT_I;
          port_d  = sel_d ? PORT_D : PORT_I;
          addr_d  = cap_addr;
          // The fetch port can never write, whatever d_we is doing.
          we_d    = sel_d & d_we;
          wdata_d = sel_d ? d_wdata : '0;
          fault_d = is_fault(cap_addr);
        end
      end
      ACCESS: begin
        state_d = RESP;
        // Stores and faulting accesses report zero data.
        rdata_d = (fault_q || we_q) ? '0 : mem_RD;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= PORT_I;
      port_q  <= PORT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are quiet while rst is high: an aborted store must not write
  // and an aborted response must not pulse rvalid.
  assign in_access = (state_q == ACCESS) && !rst;
  assign in_resp   = (state_q == RESP) && !rst;

  assign i_gnt    = gnt_vec[0];
  assign d_gnt    = gnt_vec[1];

  assign mem_A    = in_access ? addr_q : '0;
  assign mem_WD   = in_access ? wdata_q : '0;
  assign mem_We   = in_access & we_q & ~fault_q;

  assign i_rvalid = in_resp && (port_q == PORT_I);
  assign d_rvalid = in_resp && (port_q == PORT_D);
  assign i_rdata  = i_rvalid ? rdata_q : '0;
  assign d_rdata  = d_rvalid ? rdata_q : '0;
  assign err      = in_resp & fault_q;

endmodule
